key_matrix_encoder: RTL

//  Scans a physical 9-row x 8-column SAM keyboard matrix and emits PS/2-style key events in the
//  ps2_key[10:0] format: bit10 toggle strobe, bit9 pressed, bit8 extended, bits7:0 set-2 code.

---
 rtl/key_matrix_encoder.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/key_matrix_encoder.sv
// Scans a 9x8 SAM keyboard matrix with per-key debounce and emits PS/2-style
// key events through a 4-entry FIFO; a disable sweeps out releases for held keys.
module key_matrix_encoder #(
  parameter int unsigned SETTLE   = 16,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned GAP      = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  output logic [8:0]  row_n,
  input  logic [7:0]  col_n,
  output logic [10:0] ps2_key,
  output logic        busy
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned GW = $clog2(GAP + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [3:0]    DEB_LAST    = 4'(DEBOUNCE - 1);
  localparam logic [GW-1:0] GAP_LOAD    = GW'(GAP);

  typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, COMPARE, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [3:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [7:0]       raw_q, raw_d;
  logic [6:0]       flush_k_q, flush_k_d;
  logic [71:0]      stable_q, stable_d;
  logic [71:0][3:0] cnt_q, cnt_d;
  logic [3:0][9:0]  fifo_q, fifo_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [10:0]      ps2_key_q, ps2_key_d;

  logic       push;
  logic [9:0] push_data;
  logic       pop;
  logic       can_push;
  logic       advance;
  logic [6:0] key_idx;
  logic [8:0] lut_entry;

  // {extended, set-2 code} per matrix position k = row*8 + col; code 00 is unmapped
  function automatic logic [8:0] key_lut(input logic [6:0] k);
    case (k)
      7'd0:  key_lut = 9'h012; 7'd1:  key_lut = 9'h01A; 7'd2:  key_lut = 9'h022; 7'd3:  key_lut = 9'h021;
      7'd4:  key_lut = 9'h02A; 7'd5:  key_lut = 9'h005; 7'd6:  key_lut = 9'h006; 7'd7:  key_lut = 9'h004;
      7'd8:  key_lut = 9'h01C; 7'd9:  key_lut = 9'h01B; 7'd10: key_lut = 9'h023; 7'd11: key_lut = 9'h02B;
      7'd12: key_lut = 9'h034; 7'd13: key_lut = 9'h00C; 7'd14: key_lut = 9'h003; 7'd15: key_lut = 9'h00B;
      7'd16: key_lut = 9'h015; 7'd17: key_lut = 9'h01D; 7'd18: key_lut = 9'h024; 7'd19: key_lut = 9'h02D;
      7'd20: key_lut = 9'h02C; 7'd21: key_lut = 9'h083; 7'd22: key_lut = 9'h00A; 7'd23: key_lut = 9'h001;
      7'd24: key_lut = 9'h016; 7'd25: key_lut = 9'h01E; 7'd26: key_lut = 9'h026; 7'd27: key_lut = 9'h025;
      7'd28: key_lut = 9'h02E; 7'd29: key_lut = 9'h076; 7'd30: key_lut = 9'h00D; 7'd31: key_lut = 9'h058;
      7'd32: key_lut = 9'h045; 7'd33: key_lut = 9'h046; 7'd34: key_lut = 9'h03E; 7'd35: key_lut = 9'h03D;
      7'd36: key_lut = 9'h036; 7'd37: key_lut = 9'h04E; 7'd38: key_lut = 9'h055; 7'd39: key_lut = 9'h066;
      7'd40: key_lut = 9'h04D; 7'd41: key_lut = 9'h044; 7'd42: key_lut = 9'h043; 7'd43: key_lut = 9'h03C;
      7'd44: key_lut = 9'h035; 7'd45: key_lut = 9'h052; 7'd46: key_lut = 9'h054; 7'd47: key_lut = 9'h05B;
      7'd48: key_lut = 9'h05A; 7'd49: key_lut = 9'h04B; 7'd50: key_lut = 9'h042; 7'd51: key_lut = 9'h03B;
      7'd52: key_lut = 9'h033; 7'd53: key_lut = 9'h04C; 7'd54: key_lut = 9'h05D; 7'd55: key_lut = 9'h009;
      7'd56: key_lut = 9'h029; 7'd57: key_lut = 9'h011; 7'd58: key_lut = 9'h03A; 7'd59: key_lut = 9'h031;
      7'd60: key_lut = 9'h032; 7'd61: key_lut = 9'h041; 7'd62: key_lut = 9'h049; 7'd63: key_lut = 9'h04A;
      7'd64: key_lut = 9'h014; 7'd65: key_lut = 9'h175; 7'd66: key_lut = 9'h172; 7'd67: key_lut = 9'h16B;
      7'd68: key_lut = 9'h174;
      default: key_lut = 9'h000;
    endcase
  endfunction

  always_comb begin
    key_idx   = (state_q == FLUSH) ? flush_k_q : {row_q, col_q};
    lut_entry = key_lut(key_idx);
    pop       = (count_q != 3'd0) && (gap_q == '0);
    can_push  = (count_q != 3'd4) || pop;
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    settle_d  = settle_q;
    raw_d     = raw_q;
    flush_k_d = flush_k_q;
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = '0;
    advance   = 1'b1;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = DRIVE;
          settle_d = '0;
          col_d    = 3'd0;
        end
      end
      DRIVE: begin
        if (!enable) begin
          state_d   = FLUSH;
          flush_k_d = 7'd0;
          row_d     = 4'd0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      SAMPLE: begin
        if (!enable) begin
          state_d   = FLUSH;
          flush_k_d = 7'd0;
          row_d     = 4'd0;
        end else begin
          raw_d   = ~col_n;
          col_d   = 3'd0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (!enable) begin
          state_d   = FLUSH;
          flush_k_d = 7'd0;
          row_d     = 4'd0;
        end else begin
          // A debounced change that needs a FIFO slot holds this column until one frees up
          if (raw_q[col_q] != stable_q[key_idx]) begin
            if (cnt_q[key_idx] == DEB_LAST) begin
              if ((lut_entry[7:0] != 8'h00) && !can_push) begin
                advance = 1'b0;
              end else begin
                stable_d[key_idx] = raw_q[col_q];
                cnt_d[key_idx]    = 4'd0;
                if (lut_entry[7:0] != 8'h00) begin
                  push      = 1'b1;
                  push_data = {raw_q[col_q], lut_entry};
                end
              end
            end else begin
              cnt_d[key_idx] = cnt_q[key_idx] + 4'd1;
            end
          end else begin
            cnt_d[key_idx] = 4'd0;
          end
          if (advance) begin
            if (col_q == 3'd7) begin
              row_d    = (row_q == 4'd8) ? 4'd0 : row_q + 4'd1;
              settle_d = '0;
              state_d  = DRIVE;
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
      end
      FLUSH: begin
        if (stable_q[key_idx] && (lut_entry[7:0] != 8'h00)) begin
          if (!can_push) begin
            advance = 1'b0;
          end else begin
            push      = 1'b1;
            push_data = {1'b0, lut_entry};
          end
        end
        if (advance) begin
          stable_d[key_idx] = 1'b0;
          if (flush_k_q == 7'd71) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            flush_k_d = flush_k_q + 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Event FIFO and rate-limited emitter; the toggle flips on the same edge as the pop
  always_comb begin
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    gap_d     = gap_q;
    ps2_key_d = ps2_key_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 2'd1;
      ps2_key_d = {~ps2_key_q[10], fifo_q[rd_ptr_q]};
      gap_d     = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      row_q     <= 4'd0;
      col_q     <= 3'd0;
      settle_q  <= '0;
      raw_q     <= 8'h00;
      flush_k_q <= 7'd0;
      stable_q  <= '0;
      cnt_q     <= '0;
      fifo_q    <= '0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      gap_q     <= '0;
      ps2_key_q <= 11'h000;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      settle_q  <= settle_d;
      raw_q     <= raw_d;
      flush_k_q <= flush_k_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      gap_q     <= gap_d;
      ps2_key_q <= ps2_key_d;
    end
  end

  always_comb begin
    row_n = 9'h1FF;
    if ((state_q == DRIVE) || (state_q == SAMPLE) || (state_q == COMPARE)) begin
      row_n[row_q] = 1'b0;
    end
    busy    = (count_q != 3'd0) || (state_q == FLUSH);
    ps2_key = ps2_key_q;
  end

endmodule
